// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit packed-BCD counter.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX    = 4'd9;
   localparam int         NUM_DIGITS = 4;
   localparam int         DIGIT_W    = 4;

   // True when the value is a legal single BCD digit (0..9).
   function automatic bit is_bcd(input int value);
      return (value >= 0) && (value <= int'(BCD_MAX));
   endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One BCD digit: counts 0..9 on inc, clears on clr_d, flags carry and limit match.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr_d,
   input  bcd_digit_t limit,
   output bcd_digit_t digit,
   output logic       carry_out,
   output logic       hit
);

   bcd_digit_t digit_q;
   bcd_digit_t digit_next;

   // Next count value; a 9 (or any illegal nibble) rolls back to 0 so the register stays BCD.
   always_comb begin
      digit_next = digit_q + 4'd1;
      if ((digit_q == BCD_MAX) || !is_bcd(int'(digit_q))) begin
         digit_next = '0;
      end
   end

   // Digit register: clear has priority over increment, otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_q <= '0;
      end else if (clr_d) begin
         digit_q <= '0;
      end else if (inc) begin
         digit_q <= digit_next;
      end
   end

   assign digit     = digit_q;
   assign carry_out = inc && (digit_q == BCD_MAX);
   assign hit       = (digit_q == limit);

endmodule : bcd_digit

// File: rtl/bcd_counter_9675.sv
// Four-digit BCD up-counter with enable synchroniser, programmable terminal value,
// wrap-or-saturate behaviour, per-digit rollover blink toggles and a wrap pulse.
module bcd_counter_9675
   import bcd_pkg::*;
#(
   parameter int LIM3        = 9,
   parameter int LIM2        = 6,
   parameter int LIM1        = 7,
   parameter int LIM0        = 5,
   parameter int WRAP        = 1,
   parameter int SYNC_STAGES = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        clr,
   output logic [15:0] Qdata,
   output logic [3:0]  blink,
   output logic        tc,
   output logic        wrap
);

   // Illegal limits or a too-short synchroniser must stop elaboration.
   if (!is_bcd(LIM3) || !is_bcd(LIM2) || !is_bcd(LIM1) || !is_bcd(LIM0)
       || (SYNC_STAGES < 2)) begin : g_param_check
      $fatal(1, "bcd_counter_9675: LIMx must be 0..9 and SYNC_STAGES >= 2");
   end

   localparam logic [15:0] TERMINAL = {4'(LIM3), 4'(LIM2), 4'(LIM1), 4'(LIM0)};
   localparam bit          DO_WRAP  = (WRAP != 0);

   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     ena_s;
   logic [NUM_DIGITS-1:0]    inc;
   logic [NUM_DIGITS-1:0]    carry;
   logic [NUM_DIGITS-1:0]    hit;
   logic [NUM_DIGITS-1:0]    nonzero;
   bcd_digit_t               digits [NUM_DIGITS];
   logic                     at_term;
   logic                     count_step;
   logic                     term_wrap;
   logic                     clr_d;
   logic [3:0]               blink_q;
   logic                     wrap_q;

   // The raw switch level is brought into the clk domain through a plain flop chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ena};
      end
   end

   assign ena_s = sync_q[SYNC_STAGES-1];

   // Terminal detection and the three mutually exclusive actions: clear, step, terminal wrap.
   always_comb begin
      at_term    = &hit;
      count_step = ena_s && !clr && !at_term;
      term_wrap  = DO_WRAP && ena_s && !clr && at_term;
      clr_d      = clr || term_wrap;
      inc        = {carry[NUM_DIGITS-2:0], count_step};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nonzero[i] = (digits[i] != '0);
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc[i]),
         .clr_d     (clr_d),
         .limit     (TERMINAL[i*DIGIT_W +: DIGIT_W]),
         .digit     (digits[i]),
         .carry_out (carry[i]),
         .hit       (hit[i])
      );
   end

   // Blink bits flip whenever their digit returns to 0 by rollover or terminal wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_q <= '0;
      end else if (term_wrap) begin
         blink_q <= blink_q ^ nonzero;
      end else if (count_step) begin
         blink_q <= blink_q ^ carry;
      end
   end

   // Wrap pulse lasts exactly one cycle since it is recomputed every edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= term_wrap;
      end
   end

   assign Qdata = {digits[3], digits[2], digits[1], digits[0]};
   assign blink = blink_q;
   assign tc    = at_term;
   assign wrap  = wrap_q;

endmodule : bcd_counter_9675

// File: tb/tb_bcd_counter_9675.sv
// Directed bench: default 9675 wrapping counter plus a 0012 saturating instance.
module tb_bcd_counter_9675;

   localparam int TERM_DEC = 9675;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        clr;
   logic [15:0] q;
   logic [3:0]  blink;
   logic        tc;
   logic        wrap;

   logic        ena2;
   logic        clr2;
   logic [15:0] q2;
   logic [3:0]  blink2;
   logic        tc2;
   logic        wrap2;

   int n_checks;
   int n_errors;
   int wrap_seen;
   int wrap2_seen;

   // Decimal reference model of the default instance
   int       m_cnt;
   bit [3:0] m_blink;
   bit       m_wrap;
   bit [1:0] m_sync;

   bcd_counter_9675 dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .clr   (clr),
      .Qdata (q),
      .blink (blink),
      .tc    (tc),
      .wrap  (wrap)
   );

   bcd_counter_9675 #(
      .LIM3 (0), .LIM2 (0), .LIM1 (1), .LIM0 (2), .WRAP (0)
   ) dut_sat (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena2),
      .clr   (clr2),
      .Qdata (q2),
      .blink (blink2),
      .tc    (tc2),
      .wrap  (wrap2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dec_digit(input int value, input int pos);
      int d;
      d = value;
      for (int k = 0; k < pos; k++) d = d / 10;
      return d % 10;
   endfunction

   function automatic logic [15:0] to_bcd(input int value);
      return {4'(dec_digit(value, 3)), 4'(dec_digit(value, 2)),
              4'(dec_digit(value, 1)), 4'(dec_digit(value, 0))};
   endfunction

   function automatic bit all_bcd(input logic [15:0] v);
      return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_cnt   = 0;
      m_blink = '0;
      m_wrap  = 1'b0;
      m_sync  = '0;
   endtask

   // Advance n clock edges, updating the model on each posedge and checking on the negedge
   task automatic applyStimulus(input int n);
      int  old;
      bit  es;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         old    = m_cnt;
         es     = m_sync[1];
         m_sync = {m_sync[0], ena};
         if (clr) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
         end else if (es) begin
            if (old == TERM_DEC) begin
               for (int i = 0; i < 4; i++)
                  if (dec_digit(old, i) != 0) m_blink[i] = ~m_blink[i];
               m_cnt  = 0;
               m_wrap = 1'b1;
            end else begin
               m_cnt = old + 1;
               for (int i = 0; i < 4; i++)
                  if (dec_digit(old, i) == 9 && dec_digit(m_cnt, i) == 0) m_blink[i] = ~m_blink[i];
               m_wrap = 1'b0;
            end
         end else begin
            m_wrap = 1'b0;
         end
         @(negedge clk);
         checkOutput("cyc_q", 32'(q), 32'(to_bcd(m_cnt)));
         checkOutput("cyc_blink", 32'(blink), 32'(m_blink));
         checkOutput("cyc_wrap", 32'(wrap), 32'(m_wrap));
         checkOutput("cyc_tc", 32'(tc), 32'(m_cnt == TERM_DEC));
         checkOutput("cyc_bcd_legal", 32'(all_bcd(q)), 32'd1);
         if (wrap) wrap_seen++;
         if (wrap2) wrap2_seen++;
      end
   endtask

   initial begin
      bit [3:0] blink_before;
      n_checks   = 0;
      n_errors   = 0;
      wrap_seen  = 0;
      wrap2_seen = 0;
      rst  = 1'b0;
      ena  = 1'b0;
      clr  = 1'b0;
      ena2 = 1'b0;
      clr2 = 1'b0;
      modelReset();

      $display("[TB] reset state");
      repeat (3) @(negedge clk);
      checkOutput("rst_q", 32'(q), 32'h0000);
      checkOutput("rst_blink", 32'(blink), 32'h0);
      checkOutput("rst_wrap", 32'(wrap), 32'h0);
      checkOutput("rst_tc", 32'(tc), 32'h0);
      checkOutput("rst_q2", 32'(q2), 32'h0000);

      $display("[TB] enable latency");
      rst = 1'b1;
      ena = 1'b1;
      applyStimulus(2);
      checkOutput("lat_hold", 32'(q), 32'h0000);
      applyStimulus(1);
      checkOutput("lat_first", 32'(q), 32'h0001);

      $display("[TB] async reset mid-count");
      applyStimulus(436);
      checkOutput("pre_rst_q", 32'(q), 32'h0437);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_q", 32'(q), 32'h0000);
      checkOutput("async_blink", 32'(blink), 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(2);
      checkOutput("relat_hold", 32'(q), 32'h0000);
      applyStimulus(1);
      checkOutput("relat_first", 32'(q), 32'h0001);

      $display("[TB] digit carry 0099 -> 0100");
      applyStimulus(98);
      checkOutput("pre_carry_q", 32'(q), 32'h0099);
      blink_before = m_blink;
      applyStimulus(1);
      checkOutput("carry_q", 32'(q), 32'h0100);
      checkOutput("carry_blink", 32'(blink), 32'(blink_before ^ 4'b0011));
      checkOutput("carry_wrap", 32'(wrap), 32'h0);

      $display("[TB] enable hold and clear priority");
      applyStimulus(248);
      ena = 1'b0;
      applyStimulus(2);
      checkOutput("hold_start", 32'(q), 32'h0350);
      applyStimulus(10);
      checkOutput("hold_end", 32'(q), 32'h0350);
      ena = 1'b1;
      applyStimulus(2);
      checkOutput("hold_relat", 32'(q), 32'h0350);
      blink_before = m_blink;
      clr = 1'b1;
      applyStimulus(1);
      clr = 1'b0;
      checkOutput("clr_q", 32'(q), 32'h0000);
      checkOutput("clr_blink", 32'(blink), 32'(blink_before));

      $display("[TB] full sweep and terminal wrap");
      wrap_seen = 0;
      applyStimulus(TERM_DEC);
      checkOutput("term_q", 32'(q), 32'h9675);
      checkOutput("term_tc", 32'(tc), 32'h1);
      blink_before = m_blink;
      applyStimulus(1);
      checkOutput("wrap_q", 32'(q), 32'h0000);
      checkOutput("wrap_pulse", 32'(wrap), 32'h1);
      checkOutput("wrap_blink", 32'(blink), 32'(blink_before ^ 4'hF));
      checkOutput("wrap_tc", 32'(tc), 32'h0);
      applyStimulus(1);
      checkOutput("wrap_drop", 32'(wrap), 32'h0);
      checkOutput("sweep_wraps", 32'(wrap_seen), 32'd1);

      $display("[TB] saturating instance");
      ena  = 1'b0;
      ena2 = 1'b1;
      wrap2_seen = 0;
      applyStimulus(2);
      checkOutput("sat_lat", 32'(q2), 32'h0000);
      applyStimulus(12);
      checkOutput("sat_q", 32'(q2), 32'h0012);
      checkOutput("sat_tc", 32'(tc2), 32'h1);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1);
         checkOutput("sat_hold", 32'(q2), 32'h0012);
      end
      checkOutput("sat_blink", 32'(blink2), 32'h1);
      checkOutput("sat_tc_end", 32'(tc2), 32'h1);
      checkOutput("sat_no_wrap", 32'(wrap2_seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_bcd_counter_9675
